// File: rtl/uart_transmit_fifo.sv
// uart_transmit_fifo
//
// UART transmitter with a small input FIFO. The producer pushes words over a
// valid/ready handshake. Queued words are serialised onto o_tx back-to-back,
// with no idle gap between the stop bit of one frame and the next start bit.
// The frame is: start bit (0), DATA_WIDTH data bits LSB first, an optional
// parity bit, then STOP_BITS stop bits (1). Every bit lasts
// N_CLOCKS = CLOCK_FREQUENCY / BAUD_RATE clock cycles.
//
// Optional feature macro: UART_TX_BREAK_EN
//   When defined, the i_break input is present. i_break holds the line low
//   (a break) once the transmitter is idle. A frame that is already in flight
//   finishes first. When i_break is released, the line is held high for one
//   bit time (the mark) before the next frame may start.
//
// Parameters:
//   CLOCK_FREQUENCY  clock frequency in Hz
//   BAUD_RATE        line rate in bits/s (N_CLOCKS must be >= 2)
//   DATA_WIDTH       data bits per frame, 5..9
//   PARITY           0 = none, 1 = odd, 2 = even
//   STOP_BITS        1 or 2
//   FIFO_DEPTH       input FIFO entries, power of two, >= 2
//
// Ports:
//   i_clock       system clock
//   i_reset       synchronous, active-high reset
//   i_data        word to transmit
//   i_data_valid  producer has a word
//   i_break       (UART_TX_BREAK_EN only) request a line break
//   o_data_ready  FIFO can accept a word
//   o_tx          serial line, idle high
//   o_busy        frame, break or mark in progress, or FIFO non-empty
//   o_fifo_count  words currently queued, 0..FIFO_DEPTH

module uart_transmit_fifo #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_WIDTH      = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_data_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                          i_break,
`endif
  output logic                          o_data_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int N_CLOCKS   = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int PARITY_EN  = (PARITY != 0) ? 1 : 0;
  localparam int FRAME_BITS = 1 + DATA_WIDTH + PARITY_EN + STOP_BITS;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  // Keep the sample counter at least one bit wide even for an illegal
  // N_CLOCKS, so that only the $error below reports the problem.
  localparam int SAMPLE_W   = (N_CLOCKS >= 2) ? $clog2(N_CLOCKS) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(N_CLOCKS - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]    COUNT_FULL  = CNT_W'(FIFO_DEPTH);

  // Elaboration-time parameter checks.
  generate
    if (N_CLOCKS < 2) begin : g_bad_baud
      $error("uart_transmit_fifo: CLOCK_FREQUENCY / BAUD_RATE must be >= 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
      $error("uart_transmit_fifo: DATA_WIDTH must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_transmit_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_transmit_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_transmit_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef UART_TX_BREAK_EN
    ,
    BREAK,
    MARK
`endif
  } state_t;

  state_t                  state;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic [SAMPLE_W-1:0]     sample_cnt;
  logic [BIT_W-1:0]        bit_cnt;

  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fifo_count;

  logic                    push;
  logic                    pop;
  logic                    sample_last;
  logic                    launch_ok;
  logic                    break_req;

  // Full frame image, LSB is sent first. Bits above the data and parity
  // default to 1, which makes up the stop bits.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_WIDTH-1:0] d);
    logic [FRAME_BITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[DATA_WIDTH:1] = d;
    if (PARITY == 1) begin
      f[DATA_WIDTH+1] = ~(^d);
    end else if (PARITY == 2) begin
      f[DATA_WIDTH+1] = ^d;
    end
    return f;
  endfunction

`ifdef UART_TX_BREAK_EN
  assign break_req = i_break;
`else
  assign break_req = 1'b0;
`endif

  assign o_data_ready = (fifo_count != COUNT_FULL);
  assign push         = i_data_valid && o_data_ready;
  assign sample_last  = (sample_cnt == SAMPLE_LAST);

  // A new frame may be launched from idle, on the last cycle of the final
  // stop bit (back-to-back frames), or at the end of the post-break mark.
  always_comb begin
    launch_ok = 1'b0;
    case (state)
      IDLE:    launch_ok = 1'b1;
      SEND:    launch_ok = sample_last && (bit_cnt == '0);
`ifdef UART_TX_BREAK_EN
      MARK:    launch_ok = sample_last;
`endif
      default: launch_ok = 1'b0;
    endcase
  end

  assign pop = launch_ok && !break_req && (fifo_count != '0);

  // Storage is not reset: the pointers and the count define what is valid.
  always_ff @(posedge i_clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two. The count
  // tells full from empty.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // Transmit FSM. The line is always shift_reg[0]. The register holds all
  // ones when idle or in a mark, and all zeros during a break.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      shift_reg  <= '1;
      sample_cnt <= '0;
      bit_cnt    <= '0;
    end else if (launch_ok) begin
`ifdef UART_TX_BREAK_EN
      if (break_req) begin
        state      <= BREAK;
        shift_reg  <= '0;
        sample_cnt <= '0;
      end else
`endif
      if (pop) begin
        state      <= SEND;
        shift_reg  <= build_frame(fifo_mem[rd_ptr]);
        sample_cnt <= '0;
        bit_cnt    <= BIT_LAST;
      end else begin
        state      <= IDLE;
        shift_reg  <= '1;
        sample_cnt <= '0;
      end
    end else begin
      case (state)
        SEND: begin
          if (sample_last) begin
            sample_cnt <= '0;
            shift_reg  <= {1'b1, shift_reg[FRAME_BITS-1:1]};
            bit_cnt    <= bit_cnt - BIT_W'(1);
          end else begin
            sample_cnt <= sample_cnt + SAMPLE_W'(1);
          end
        end
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          if (!i_break) begin
            state      <= MARK;
            shift_reg  <= '1;
            sample_cnt <= '0;
          end
        end
        MARK: begin
          sample_cnt <= sample_cnt + SAMPLE_W'(1);
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign o_tx         = shift_reg[0];
  assign o_busy       = (state != IDLE) || (fifo_count != '0);
  assign o_fifo_count = fifo_count;

endmodule

// File: tb/tb_uart_transmit_fifo.sv
// tb_uart_transmit_fifo
//
// Scoreboard bench for uart_transmit_fifo. Accepted words are queued as
// expected frames. A monitor decodes the serial line at the falling clock
// edge and compares every bit period against the frame image. The frame
// image is rebuilt from the data, the parity mode and the stop-bit count.
// Two extra instances run a 7-bit, 2-stop-bit configuration with even and
// odd parity.

module tb_uart_transmit_fifo;

  localparam int N      = 16;
  localparam int DW     = 8;
  localparam int FD     = 4;
  localparam int FRAME  = 10;
  localparam int PN     = 4;
  localparam int PFRAME = 11;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] data    = '0;
  logic       valid   = 1'b0;
  wire        ready;
  wire        tx;
  wire        busy;
  wire  [2:0] fcount;

  logic [6:0] p_data  = '0;
  logic       p_valid = 1'b0;
  wire        pe_ready, pe_tx, pe_busy;
  wire        po_ready, po_tx, po_busy;
  wire  [2:0] pe_count, po_count;

`ifdef UART_TX_BREAK_EN
  logic       brk = 1'b0;
`endif

  always #5 i_clock = ~i_clock;

  uart_transmit_fifo #(
    .CLOCK_FREQUENCY(16), .BAUD_RATE(1), .DATA_WIDTH(DW),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(FD)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_data(data), .i_data_valid(valid),
`ifdef UART_TX_BREAK_EN
    .i_break(brk),
`endif
    .o_data_ready(ready), .o_tx(tx), .o_busy(busy), .o_fifo_count(fcount)
  );

  uart_transmit_fifo #(
    .CLOCK_FREQUENCY(8), .BAUD_RATE(2), .DATA_WIDTH(7),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_even (
    .i_clock(i_clock), .i_reset(i_reset), .i_data(p_data), .i_data_valid(p_valid),
`ifdef UART_TX_BREAK_EN
    .i_break(1'b0),
`endif
    .o_data_ready(pe_ready), .o_tx(pe_tx), .o_busy(pe_busy), .o_fifo_count(pe_count)
  );

  uart_transmit_fifo #(
    .CLOCK_FREQUENCY(8), .BAUD_RATE(2), .DATA_WIDTH(7),
    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_odd (
    .i_clock(i_clock), .i_reset(i_reset), .i_data(p_data), .i_data_valid(p_valid),
`ifdef UART_TX_BREAK_EN
    .i_break(1'b0),
`endif
    .o_data_ready(po_ready), .o_tx(po_tx), .o_busy(po_busy), .o_fifo_count(po_count)
  );

  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;

  logic [7:0] sb_q[$];
  int         start_cyc[$];
  int         model_count = 0;
  int         m_peak = 0;
  bit         mon_en = 1'b0;
  bit         mon_hold = 1'b0;
  bit         m_active = 1'b0;
  logic [15:0] m_bits;
  int         m_bit, m_cyc, m_good;

  always @(posedge i_clock) cyc <= cyc + 1;

  // Frame image from the line rules: start 0, data LSB first, parity making
  // the total count of ones odd (1) or even (2), then the stop bits (the
  // ones that are left over).
  function automatic logic [15:0] frameBits(input logic [8:0] d, input int dw, input int par);
    logic [15:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < dw; i++) begin
      f[i + 1] = d[i];
      if (d[i]) ones++;
    end
    if (par == 1) f[dw + 1] = ((ones % 2) == 0);
    if (par == 2) f[dw + 1] = ((ones % 2) == 1);
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Push one word: wait (bounded) for ready, hand it over on the next edge
  // and queue it as an expected frame.
  task automatic applyStimulus(input logic [7:0] d);
    int guard;
    guard = 0;
    @(negedge i_clock);
    data  = d;
    valid = 1'b1;
    while (ready !== 1'b1 && guard < 4000) begin
      @(negedge i_clock);
      guard++;
    end
    if (guard >= 4000) begin
      checkOutput("ready_timeout", 32'(ready), 32'd1);
      valid = 1'b0;
    end else begin
      @(posedge i_clock);
      sb_q.push_back(d);
      model_count++;
      #1 valid = 1'b0;
    end
  endtask

  task automatic waitIdle(input int budget);
    int guard;
    guard = 0;
    @(negedge i_clock);
    while ((busy !== 1'b0 || m_active || sb_q.size() != 0) && guard < budget) begin
      @(negedge i_clock);
      guard++;
    end
    if (guard >= budget) checkOutput("drain_timeout", 32'(busy), 32'd0);
  endtask

  // Push one word into both parity instances and check each bit at its
  // second cycle, then check the exact frame length.
  task automatic parityFrame(input logic [6:0] d);
    logic [15:0] exp_e, exp_o;
    exp_e = frameBits(9'(d), 7, 2);
    exp_o = frameBits(9'(d), 7, 1);
    @(negedge i_clock);
    checkOutput("par_ready", 32'(pe_ready && po_ready), 32'd1);
    p_data  = d;
    p_valid = 1'b1;
    @(posedge i_clock);
    #1 p_valid = 1'b0;
    @(posedge i_clock);
    #1;
    for (int b = 0; b < PFRAME; b++) begin
      @(posedge i_clock);
      #1;
      checkOutput($sformatf("even_bit%0d", b), 32'(pe_tx), 32'(exp_e[b]));
      checkOutput($sformatf("odd_bit%0d", b), 32'(po_tx), 32'(exp_o[b]));
      repeat (PN - 1) @(posedge i_clock);
    end
    #1;
    checkOutput("even_done", 32'({pe_busy, pe_tx}), 32'b01);
    checkOutput("odd_done", 32'({po_busy, po_tx}), 32'b01);
  endtask

  // Monitor: frame decoding, FIFO occupancy and ready against the model.
  initial begin
    logic [7:0] w;
    forever begin
      @(negedge i_clock);
      if (mon_en) begin
        if (i_reset) begin
          m_active = 1'b0;
        end else begin
          if (!m_active && !mon_hold && tx === 1'b0) begin
            if (sb_q.size() == 0) begin
              checkOutput("idle_line", 32'(tx), 32'd1);
            end else begin
              w = sb_q.pop_front();
              m_bits = frameBits(9'(w), DW, 0);
              m_active = 1'b1;
              m_bit = 0;
              m_cyc = 0;
              m_good = 0;
              model_count--;
              start_cyc.push_back(cyc);
            end
          end
          if (m_active) begin
            if (tx === m_bits[m_bit]) m_good++;
            m_cyc++;
            if (m_cyc == N) begin
              checkOutput($sformatf("frame_bit%0d_cycles", m_bit), 32'(m_good), 32'(N));
              m_bit++;
              m_cyc = 0;
              m_good = 0;
              if (m_bit == FRAME) m_active = 1'b0;
            end
          end
          if (int'(fcount) > m_peak) m_peak = int'(fcount);
          checkOutput("fifo_count", 32'(fcount), 32'(model_count));
          checkOutput("data_ready", 32'(ready), 32'(model_count != FD));
        end
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0;
    int target;

    // Reset values.
    repeat (3) @(posedge i_clock);
    #1;
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_count", 32'(fcount), 32'd0);
    @(negedge i_clock);
    i_reset = 1'b0;
    mon_en  = 1'b1;

    // Single word: start bit one cycle after the accept, exact frame length.
    applyStimulus(8'hA5);
    checkOutput("latency_pre", 32'(tx), 32'd1);
    @(posedge i_clock);
    #1 checkOutput("latency_start", 32'(tx), 32'd0);
    repeat (FRAME * N - 1) @(posedge i_clock);
    #1 checkOutput("frame_last_busy", 32'(busy), 32'd1);
    @(posedge i_clock);
    #1 checkOutput("frame_end_busy", 32'(busy), 32'd0);
    checkOutput("frame_end_tx", 32'(tx), 32'd1);

    // Four words on consecutive cycles: peak count 3, zero-gap frames.
    waitIdle(100);
    m_peak = 0;
    s0 = start_cyc.size();
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i));
    waitIdle(6 * FRAME * N);
    checkOutput("burst4_peak", 32'(m_peak), 32'd3);
    checkOutput("burst4_frames", 32'(start_cyc.size() - s0), 32'd4);
    if (start_cyc.size() - s0 == 4) begin
      for (int i = 1; i < 4; i++)
        checkOutput("burst4_gap", 32'(start_cyc[s0 + i] - start_cyc[s0 + i - 1]), 32'(FRAME * N));
    end

    // Six words: the FIFO fills, ready drops, order is preserved.
    m_peak = 0;
    for (int i = 1; i <= 6; i++) applyStimulus(8'(8'h10 + i));
    waitIdle(9 * FRAME * N);
    checkOutput("burst6_peak", 32'(m_peak), 32'(FD));

    // Random words with random gaps.
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 200)) @(negedge i_clock);
      applyStimulus(8'($urandom_range(0, 255)));
    end
    waitIdle(20 * FRAME * N);

    // Reset in the middle of a data bit with two words queued.
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom_range(0, 255)));
    repeat (3 * N + N / 2) @(posedge i_clock);
    s0 = start_cyc.size();
    @(negedge i_clock);
    i_reset = 1'b1;
    @(posedge i_clock);
    sb_q.delete();
    model_count = 0;
    #1;
    checkOutput("abort_tx", 32'(tx), 32'd1);
    checkOutput("abort_count", 32'(fcount), 32'd0);
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
    repeat (3 * FRAME * N) @(posedge i_clock);
    #1;
    checkOutput("abort_no_frames", 32'(start_cyc.size() - s0), 32'd0);
    checkOutput("abort_idle_busy", 32'(busy), 32'd0);

    // Parity and two stop bits.
    parityFrame(7'h03);
    parityFrame(7'($urandom_range(0, 127)));
    parityFrame(7'($urandom_range(0, 127)));

`ifdef UART_TX_BREAK_EN
    // Break requested mid-frame: frame completes, line low, mark, resume.
    applyStimulus(8'h5A);
    repeat (2 * N) @(posedge i_clock);
    @(negedge i_clock);
    brk      = 1'b1;
    mon_hold = 1'b1;
    applyStimulus(8'hC3);
    target = start_cyc[start_cyc.size() - 1] + FRAME * N;
    while (cyc < target) begin
      @(posedge i_clock);
      #1;
    end
    checkOutput("break_tx", 32'(tx), 32'd0);
    checkOutput("break_busy", 32'(busy), 32'd1);
    checkOutput("break_count", 32'(fcount), 32'd1);
    repeat (40) @(posedge i_clock);
    #1 checkOutput("break_hold", 32'(tx), 32'd0);
    @(negedge i_clock);
    brk = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(posedge i_clock);
      #1;
      checkOutput("break_mark", 32'({busy, tx}), 32'b11);
    end
    mon_hold = 1'b0;
    @(posedge i_clock);
    #1 checkOutput("break_resume", 32'(tx), 32'd0);
    waitIdle(3 * FRAME * N);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_transmit_fifo.md
Name: uart_transmit_fifo

Overview:
Parametrised UART transmitter for the sim transactor and SoC debug path. It replaces the fixed 8N1, single-buffer transmitter. Data width, parity and stop-bit count are configurable, and a FIFO_DEPTH-entry input FIFO lets a producer burst words that are then sent back-to-back with no idle gap. The producer side uses a valid/ready handshake and the serial side drives one TX line.

Parameters:
CLOCK_FREQUENCY, 100000000, clock frequency in Hz
BAUD_RATE, 115200, line rate in bits/s; N_CLOCKS = CLOCK_FREQUENCY / BAUD_RATE (integer division), must be >= 2
DATA_WIDTH, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 4, input FIFO entries, power of two, >= 2

Ports:
i_clock  input  1  system clock
i_reset  input  1  synchronous, active-high reset
i_data  input  DATA_WIDTH  word to transmit
i_data_valid  input  1  producer has a word
o_data_ready  output  1  FIFO can accept a word
o_tx  output  1  serial line, idle high
o_busy  output  1  frame in progress or FIFO non-empty
o_fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently queued, 0..FIFO_DEPTH

Behaviour:
- Reset: single clock, reset synchronous and active-high, sampled on rising i_clock.
- Reset values: o_tx=1, o_data_ready=1, o_busy=0, o_fifo_count=0. FIFO pointers, bit counter and sample counter all cleared.
- Reset mid-frame aborts the frame: o_tx=1 on the cycle after reset is sampled, and FIFO contents are discarded.
- Handshake: a word is pushed on an edge where i_data_valid && o_data_ready. o_data_ready = (count != FIFO_DEPTH), combinational from registered count. i_data need only be stable on the accepting edge.
- Frame: FRAME_BITS = 1 + DATA_WIDTH + (PARITY != 0) + STOP_BITS. Bits are sent in this order:
  - start bit (0)
  - data bits, LSB first
  - parity bit, if enabled: odd makes the total of data+parity ones odd; even makes it even
  - STOP_BITS stop bits (1)
- Bit timing: each bit lasts exactly N_CLOCKS cycles, so a frame lasts exactly FRAME_BITS*N_CLOCKS cycles.
- States: IDLE, SEND.
  - IDLE -> SEND on an edge where the FIFO is non-empty. That edge pops the head word, loads the shift register and zeroes the sample counter; o_tx=0 from that edge.
  - SEND: sample counter counts 0..N_CLOCKS-1. At N_CLOCKS-1 the shift register advances (shifting in 1) and the bit counter decrements.
  - On the final cycle of the last stop bit: if the FIFO is non-empty, pop and reload on the same edge (start bit immediately follows the stop bit, zero gap). Otherwise go to IDLE with o_tx=1.
- Latency: a word accepted on edge k into an empty FIFO while IDLE makes o_tx low after edge k+1.
- Simultaneous push and pop: o_fifo_count is unchanged, and the pushed word is queued behind the popped one. A push into a full FIFO cannot occur because ready=0.
- Pointers: wrap modulo FIFO_DEPTH. The count register disambiguates full from empty.
- o_busy = (state == SEND) || (count != 0).
- Arithmetic: all counters are explicitly sized and wrap-free by construction. N_CLOCKS < 2, or any illegal parameter value, triggers an elaboration-time $error.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined: adds input i_break (1 bit).
  - While i_break=1 and the state is IDLE, o_tx is driven 0 and no word is popped.
  - i_break asserted during SEND takes effect only after the current frame's last stop bit.
  - On deassertion, o_tx=1 is held for one full bit time (N_CLOCKS cycles) before the next frame may start.
  - o_busy=1 while a break or that mark time is active.
- Undefined: i_break port is absent, and o_tx is never low outside a start or data/parity bit.

Test Plan:
- Default parameters with CLOCK_FREQUENCY=16 and BAUD_RATE=1 (N_CLOCKS=16); push 0xA5 when idle -> o_tx low 1 cycle after accept, bits 1,0,1,0,0,1,0,1 each 16 cycles, stop high, frame = 160 cycles, then o_busy=0.
- Push 4 words 0x01..0x04 on consecutive cycles with FIFO_DEPTH=4 -> o_data_ready never drops; o_fifo_count peaks at 3 (word 1 popped 1 cycle after its push); four frames back-to-back with no idle cycle between stop and start bits.
- Hold valid with 6 words -> ready=0 while count=4; no word lost or duplicated; serial output order is 1..6.
- DATA_WIDTH=7, PARITY=2, STOP_BITS=2, data 0x03 -> parity bit 0, two stop bits, frame = 11*N_CLOCKS; repeat with PARITY=1 -> parity bit 1.
- Assert reset mid-data-bit with 2 words queued -> next cycle o_tx=1, o_fifo_count=0, ready=1, no further frames.
- UART_TX_BREAK_EN: assert i_break mid-frame -> frame completes, then o_tx=0 until deassert, then N_CLOCKS of mark, then the queued word starts.
